// File: rtl/png_seq_pkg.sv
// Shared definitions for the PNG row sequencer: FSM encoding, channel-mask
// and saturating-increment helpers.
package png_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_WAIT,
    ST_GAP
  } state_e;

  // A 3-bit channel count can name at most 7 channels.
  localparam int unsigned MASK_MAX = 8;

  // Channel counts of 0 or above chn_max select every channel.
  function automatic logic [MASK_MAX-1:0] chn_mask(input logic [2:0]  chn,
                                                   input int unsigned chn_max);
    int unsigned         n;
    logic [MASK_MAX-1:0] m;
    n = {29'd0, chn};
    if (n == 0 || n > chn_max) n = chn_max;
    m = '0;
    for (int i = 0; i < MASK_MAX; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0]  v,
                                          input int unsigned wd);
    logic [31:0] ones;
    ones = (wd >= 32) ? '1 : ((32'd1 << wd) - 32'd1);
    return (v >= ones) ? ones : v + 32'd1;
  endfunction

endpackage

// File: rtl/png_row_seq_pack.sv
// Pixel output stage: zeroes channels beyond the configured count and
// registers the pixel toward the core.
module png_chn_pack #(
  parameter int CHN_MAX = 4,
  parameter int CHN_WD  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHN_MAX-1:0]        mask_i,
  input  logic                      val_i,
  input  logic [CHN_MAX*CHN_WD-1:0] dat_i,
  output logic                      val_o,
  output logic [CHN_MAX*CHN_WD-1:0] dat_o
);

  logic [CHN_MAX*CHN_WD-1:0] masked;
  logic                      val_q;
  logic [CHN_MAX*CHN_WD-1:0] dat_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    masked = '0;
    for (int c = 0; c < CHN_MAX; c++) begin
      if (mask_i[c]) masked[c*CHN_WD +: CHN_WD] = dat_i[c*CHN_WD +: CHN_WD];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= 1'b0;
      dat_q <= '0;
    end else begin
      val_q <= val_i;
      if (val_i) dat_q <= masked;
    end
  end

  assign val_o = val_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/png_row_seq.sv
// Frame-level row sequencer feeding png_top: one core start per row, pixel
// streaming with channel padding, inter-row gap and row latency reporting.
module png_row_seq
  import png_seq_pkg::*;
#(
  parameter int SIZE_W_WD = 12,
  parameter int SIZE_H_WD = 12,
  parameter int CHN_MAX   = 4,
  parameter int CHN_WD    = 8,
  parameter int GAP_CYC   = 10,
  parameter int CYC_WD    = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE_W_WD-1:0]      cfg_w_i,
  input  logic [SIZE_H_WD-1:0]      cfg_h_i,
  input  logic [2:0]                cfg_chn_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  input  logic                      src_val_i,
  input  logic [CHN_MAX*CHN_WD-1:0] src_dat_i,
  output logic                      src_rdy_o,
  output logic                      core_start_o,
  output logic                      core_val_o,
  output logic [CHN_MAX*CHN_WD-1:0] core_dat_o,
  input  logic                      core_done_i,
  output logic [SIZE_H_WD-1:0]      row_idx_o,
  output logic [CYC_WD-1:0]         row_cyc_o,
  output logic                      row_cyc_val_o,
  output logic [CYC_WD-1:0]         max_cyc_o
);

  localparam int GAP_WD = $clog2(GAP_CYC + 1);
  localparam logic [GAP_WD-1:0] GAP_LAST = GAP_WD'(GAP_CYC - 1);

  state_e               state_q, state_d;
  logic [SIZE_W_WD-1:0] w_q, w_d;
  logic [SIZE_H_WD-1:0] h_q, h_d;
  logic [CHN_MAX-1:0]   mask_q, mask_d;
  logic [SIZE_W_WD-1:0] pix_q, pix_d;
  logic [GAP_WD-1:0]    gap_q, gap_d;
  logic [CYC_WD-1:0]    lat_q, lat_d;
  logic [SIZE_H_WD-1:0] row_q, row_d;
  logic [CYC_WD-1:0]    row_cyc_q, row_cyc_d;
  logic                 row_cyc_val_q, row_cyc_val_d;
  logic [CYC_WD-1:0]    max_q, max_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [MASK_MAX-1:0]  mask_full;
  logic [CHN_MAX-1:0]   mask_cfg;
  logic [CYC_WD-1:0]    lat_inc;
  logic                 rdy;
  logic                 hs;

  assign mask_full = chn_mask(cfg_chn_i, CHN_MAX);
  assign mask_cfg  = mask_full[CHN_MAX-1:0];
  assign lat_inc   = CYC_WD'(sat_inc(32'(lat_q), CYC_WD));
  assign rdy       = (state_q == ST_DATA) && (pix_q < w_q);
  assign hs        = src_val_i && rdy;

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    h_d           = h_q;
    mask_d        = mask_q;
    pix_d         = pix_q;
    gap_d         = gap_q;
    lat_d         = lat_q;
    row_d         = row_q;
    row_cyc_d     = row_cyc_q;
    row_cyc_val_d = 1'b0;
    max_d         = max_q;
    done_d        = 1'b0;
    err_d         = err_q;

    // A core done anywhere but WAIT is flagged and otherwise ignored.
    if (core_done_i && state_q != ST_WAIT) err_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          w_d    = cfg_w_i;
          h_d    = cfg_h_i;
          mask_d = mask_cfg;
          err_d  = 1'b0;
          max_d  = '0;
          row_d  = '0;
          if (cfg_w_i == '0 || cfg_h_i == '0) begin
            done_d = 1'b1;
          end else begin
            lat_d   = '0;
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        lat_d   = lat_inc;
        pix_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        lat_d = lat_inc;
        if (hs) begin
          pix_d = pix_q + SIZE_W_WD'(1);
          if (pix_q == w_q - SIZE_W_WD'(1)) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_done_i) begin
          row_cyc_d     = lat_q;
          row_cyc_val_d = 1'b1;
          if (lat_q > max_q) max_d = lat_q;
          if (row_q == h_q - SIZE_H_WD'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end else begin
          lat_d = lat_inc;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          row_d   = row_q + SIZE_H_WD'(1);
          lat_d   = '0;
          state_d = ST_START;
        end else begin
          gap_d = gap_q + GAP_WD'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      w_q           <= '0;
      h_q           <= '0;
      mask_q        <= '0;
      pix_q         <= '0;
      gap_q         <= '0;
      lat_q         <= '0;
      row_q         <= '0;
      row_cyc_q     <= '0;
      row_cyc_val_q <= 1'b0;
      max_q         <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      w_q           <= w_d;
      h_q           <= h_d;
      mask_q        <= mask_d;
      pix_q         <= pix_d;
      gap_q         <= gap_d;
      lat_q         <= lat_d;
      row_q         <= row_d;
      row_cyc_q     <= row_cyc_d;
      row_cyc_val_q <= row_cyc_val_d;
      max_q         <= max_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  png_chn_pack #(
    .CHN_MAX (CHN_MAX),
    .CHN_WD  (CHN_WD)
  ) u_pack (
    .clk    (clk),
    .rst    (rst),
    .mask_i (mask_q),
    .val_i  (hs),
    .dat_i  (src_dat_i),
    .val_o  (core_val_o),
    .dat_o  (core_dat_o)
  );

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign src_rdy_o     = rdy;
  assign core_start_o  = (state_q == ST_START);
  assign row_idx_o     = row_q;
  assign row_cyc_o     = row_cyc_q;
  assign row_cyc_val_o = row_cyc_val_q;
  assign max_cyc_o     = max_q;

endmodule

// File: tb/tb_png_row_seq.sv
// Directed bench for png_row_seq: multi-row frames, channel masking, source
// stalls, empty frames, error flag and mid-frame reset.
module tb_png_row_seq;

  localparam int SW = 12;
  localparam int SH = 12;
  localparam int CW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] cfg_w;
  logic [SH-1:0] cfg_h;
  logic [2:0]    cfg_chn;
  logic          start;
  logic          busy, done, err;
  logic          src_val;
  logic [DW-1:0] src_dat;
  logic          src_rdy;
  logic          core_start, core_val;
  logic [DW-1:0] core_dat;
  logic          core_done;
  logic [SH-1:0] row_idx;
  logic [CW-1:0] row_cyc, max_cyc;
  logic          row_cyc_val;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  png_row_seq #(
    .SIZE_W_WD (SW),
    .SIZE_H_WD (SH),
    .CHN_MAX   (4),
    .CHN_WD    (8),
    .GAP_CYC   (3),
    .CYC_WD    (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_w_i       (cfg_w),
    .cfg_h_i       (cfg_h),
    .cfg_chn_i     (cfg_chn),
    .start_i       (start),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .src_val_i     (src_val),
    .src_dat_i     (src_dat),
    .src_rdy_o     (src_rdy),
    .core_start_o  (core_start),
    .core_val_o    (core_val),
    .core_dat_o    (core_dat),
    .core_done_i   (core_done),
    .row_idx_o     (row_idx),
    .row_cyc_o     (row_cyc),
    .row_cyc_val_o (row_cyc_val),
    .max_cyc_o     (max_cyc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
    check({tag, " src_rdy"}, src_rdy, 0);
    check({tag, " core_start"}, core_start, 0);
    check({tag, " core_val"}, core_val, 0);
    check({tag, " core_dat"}, core_dat, 0);
    check({tag, " row_idx"}, row_idx, 0);
    check({tag, " row_cyc"}, row_cyc, 0);
    check({tag, " row_cyc_val"}, row_cyc_val, 0);
    check({tag, " max_cyc"}, max_cyc, 0);
  endtask

  // Entered in the core_start cycle S of a 4-pixel row with the source always
  // valid; the core answers 7 cycles later. Returns in the next row's S, or
  // one cycle after the last row's done.
  task automatic row_4x(input int idx, input bit last);
    check("row start", core_start, 1);
    check("row idx", row_idx, idx);
    tick();
    check("row first rdy", src_rdy, 1);
    check("row start pulse", core_start, 0);
    tick_n(6);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("row cyc val", row_cyc_val, 1);
    check("row cyc", row_cyc, 7);
    check("row max", max_cyc, 7);
    check("row done", done, last);
    check("row busy", busy, !last);
    if (!last) begin
      tick_n(2);
      check("gap no start", core_start, 0);
      tick();
    end
  endtask

  task automatic frame_w3(input logic [2:0] chn, input logic [DW-1:0] exp_dat);
    cfg_w = 3; cfg_h = 1; cfg_chn = chn;
    src_dat = 32'hAABBCCDD; src_val = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_n(2);
    check("mask val", core_val, 1);
    check("mask dat", core_dat, exp_dat);
    tick_n(2);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("w3 done", done, 1);
    check("w3 row_cyc", row_cyc, 4);
  endtask

  initial begin
    int k, nval, nhs;
    rst = 1'b1; start = 1'b0; cfg_w = '0; cfg_h = '0; cfg_chn = '0;
    src_val = 1'b0; src_dat = '0; core_done = 1'b0;
    tick_n(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Two-row frame: starts 11 cycles apart with GAP_CYC=3.
    cfg_w = 4; cfg_h = 2; cfg_chn = 4;
    src_val = 1'b1; src_dat = 32'h01020304;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("frame busy", busy, 1);
    check("frame first rdy low", src_rdy, 0);
    row_4x(0, 1'b0);
    row_4x(1, 1'b1);
    tick();
    check("done single pulse", done, 0);

    // Channel masking.
    frame_w3(3'd1, 32'h000000DD);
    frame_w3(3'd3, 32'h00BBCCDD);
    frame_w3(3'd0, 32'hAABBCCDD);

    // Source valid every other cycle.
    cfg_w = 5; cfg_h = 1; cfg_chn = 4;
    src_val = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; nval = 0; nhs = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (core_val) begin
        check("stall dat", core_dat, 32'h11000000 + nval);
        nval++;
      end
      src_val = i[0];
      src_dat = 32'h11000000 + k;
      check("stall rdy", src_rdy, (i <= 9));
      if (src_val && src_rdy) begin
        nhs++;
        k++;
      end
    end
    src_val = 1'b0;
    check("stall val count", nval, 5);
    check("stall hs count", nhs, 5);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("stall done", done, 1);
    check("stall row_cyc", row_cyc, 14);

    // Empty frame.
    cfg_w = 4; cfg_h = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty done", done, 1);
    check("empty busy", busy, 0);
    check("empty core_start", core_start, 0);
    tick();
    check("empty done pulse", done, 0);
    check("empty no start", core_start, 0);
    check("empty busy after", busy, 0);

    // Stray core done during DATA.
    cfg_w = 2; cfg_h = 1; cfg_chn = 4; src_val = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err clear", err, 0);
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("err set", err, 1);
    check("err busy", busy, 1);
    check("err no row_cyc_val", row_cyc_val, 0);
    src_val = 1'b1;
    tick_n(2);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("err frame done", done, 1);
    check("err frame row_cyc", row_cyc, 4);
    check("err sticky", err, 1);
    tick();
    check("err sticky idle", err, 1);

    // Next frame clears err; reset during row 1 DATA.
    cfg_w = 4; cfg_h = 2; cfg_chn = 4; src_dat = 32'h01020304;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err cleared by start", err, 0);
    row_4x(0, 1'b0);
    tick_n(2);
    check("pre-reset rdy", src_rdy, 1);
    check("pre-reset row", row_idx, 1);
    rst = 1'b1;
    tick();
    check_all_zero("midreset");
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    row_4x(0, 1'b0);
    row_4x(1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
